sprite_tiler: RTL
=================

SPRITE_TILER -- requirements
Module: sprite_tiler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WIDTH, 315, sprite width in pixels.
- HEIGHT, 262, sprite height in lines.
- TILES_X, 2, horizontal repeat count, at least 1.
- TILES_Y, 1, vertical repeat count, at least 1.
- ADDR_W, 17, image ROM address width; at least clog2(WIDTH*HEIGHT).
- IDX_W, 8, colour-index width.
- RGB_W, 24, pixel width.
- ROM_LAT, 1, image ROM read latency in cycles, at least 1.
- MAP_LAT, 1, colour-map read latency in cycles, at least 1.
- TRANS_EN, 0, transparency enable.
- TRANS_IDX, 0, transparent colour index.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all logic on its rising edge.
- reset_n, in, 1, asynchronous, active-low reset.
- x, in, 11, sprite left edge.
- y, in, 10, sprite top edge.
- hcount, in, 11, current pixel column.
- vcount, in, 10, current line.
- frame_start, in, 1, one-cycle pulse at start of vertical blanking.
- mirror, in, 1, horizontally mirror odd-numbered tiles.
- rom_addr, out, ADDR_W, image ROM address.
- rom_data, in, IDX_W, image ROM data.
- map_addr, out, IDX_W, colour-map address.
- map_data, in, RGB_W, colour-map data.
- pixel, out, RGB_W, output colour.
- pixel_valid, out, 1, pixel is an opaque sprite pixel.

Function
REQ-003 Capture: x, y and mirror SHALL be captured into x_q, y_q and mir_q only on cycles with frame_start=1, so the sprite never tears mid-frame.
REQ-004 Column tracking: on a cycle with hcount==x_q, the column counter SHALL load col=0, tile_x=0, col_active=1.
REQ-005 While col_active=1, col SHALL increment each cycle. At col==WIDTH-1 it SHALL wrap to 0 and increment tile_x. At tile_x==TILES_X-1 with col==WIDTH-1, col_active SHALL clear.
REQ-006 Row tracking: on a cycle with hcount==0 and vcount==y_q, the row counter SHALL load row=0, row_base=0, tile_y=0, row_active=1.
REQ-007 On other hcount==0 cycles with row_active=1, row SHALL increment and row_base SHALL increase by WIDTH. At row==HEIGHT-1, row and row_base SHALL wrap to 0 and tile_y SHALL increment. After the last line of tile TILES_Y-1, row_active SHALL clear.
REQ-008 No multiplier SHALL be used; addresses come only from the counters and adders.
REQ-009 Effective column col_eff SHALL be WIDTH-1-col when mir_q=1 and tile_x is odd; otherwise col_eff=col.
REQ-010 rom_addr SHALL be registered as row_base+col_eff when col_active and row_active are both 1, and as 0 otherwise.
REQ-011 map_addr SHALL equal rom_data combinationally.
REQ-012 Latency: the column state is available at n+1 and rom_addr at n+2 for hcount at cycle n. pixel and pixel_valid for that hcount SHALL be registered at cycle n+L, where L=3+ROM_LAT+MAP_LAT (5 at defaults).
REQ-013 An in-range flag, and the colour index when TRANS_EN=1, SHALL be carried in a delay pipeline aligned to map_data.
REQ-014 At cycle n+L: if in range and not transparent, pixel SHALL be map_data and pixel_valid SHALL be 1; otherwise pixel SHALL be 0 and pixel_valid SHALL be 0.
REQ-015 Transparent means TRANS_EN=1 and the index equals TRANS_IDX.
REQ-016 A sprite extending past hcount 2047 or vcount 1023 SHALL simply be clipped; counters SHALL NOT wrap onto the left edge or the top.
REQ-017 If frame_start arrives while the row or column counters are active, the counters SHALL continue unaffected; new x_q/y_q take effect at the next matching hcount/vcount.
REQ-018 If hcount==x_q recurs while col_active=1, the column counter SHALL restart at col=0.

Reset
REQ-019 With reset_n=0, the following SHALL be 0 immediately, asynchronously: x_q, y_q, mir_q, all counters, all active flags, all pipeline stages, rom_addr, pixel, pixel_valid.
REQ-020 Reset asserted mid-line SHALL flush the pipeline; no stale pixels SHALL appear after release.
REQ-021 After release, no sprite SHALL draw until the first frame_start.

Structure
REQ-022 The latency formula L and shared default constants (WIDTH, HEIGHT, ROM_LAT, MAP_LAT) SHALL live in a shared display package.
REQ-023 The ROMs SHALL stay outside this block.
REQ-024 One sub-module, sprite_delay_line (parametrised width and depth shift register), SHALL implement the alignment pipelines.

Verification
REQ-025 Tile address: WIDTH=4, HEIGHT=2, TILES_X=2, x=10, y=5. Sweep lines 5-6 -> rom_addr sequence 0,1,2,3,0,1,2,3 then 4,5,6,7,4,5,6,7; pixel_valid=1 for exactly 8 pixels per line, hcount 10-17, delayed by L.
REQ-026 Mirror: same setup with mirror=1 -> line 5 sequence 0,1,2,3,3,2,1,0.
REQ-027 Transparency: TRANS_EN=1, TRANS_IDX=0, rom_data=0 at col 2 -> that pixel has pixel=0, pixel_valid=0; neighbouring pixels are valid.
REQ-028 Latency: ROM_LAT=2, MAP_LAT=3 -> the first valid pixel appears exactly 8 cycles after hcount==x.
REQ-029 Capture: change x from 10 to 50 mid-frame without frame_start -> no shift; after frame_start, the next frame starts at hcount 50.
REQ-030 Reset: drive reset_n=0 at cycle 3 of a sprite line -> pixel and pixel_valid go 0 asynchronously; after release with no frame_start, all pixels stay 0.

Source files
------------

// File: rtl/sprite_tiler_pkg.sv
// Shared display constants and the pixel-pipeline latency helper for the sprite tiler.
package sprite_tiler_pkg;

  localparam int DEF_WIDTH   = 315;
  localparam int DEF_HEIGHT  = 262;
  localparam int DEF_ROM_LAT = 1;
  localparam int DEF_MAP_LAT = 1;

  // Fixed stages: column register, ROM address register, pixel output register.
  localparam int FRONT_LAT   = 3;

  function automatic int sprite_latency(input int rom_lat, input int map_lat);
    return FRONT_LAT + rom_lat + map_lat;
  endfunction

endpackage

// File: rtl/sprite_tiler_delay_line.sv
// Resettable shift register used to align side-band data with the ROM/colour-map reads.
module sprite_delay_line
  import sprite_tiler_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] stage_q [DEPTH];

  // Shift chain; reset flushes every stage so no stale data survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sprite_tiler.sv
// Tiled sprite renderer: walks an external image ROM and colour map, emitting
// opaque sprite pixels aligned to hcount with a fixed pipeline latency.
module sprite_tiler
  import sprite_tiler_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HEIGHT    = DEF_HEIGHT,
  parameter int TILES_X   = 2,
  parameter int TILES_Y   = 1,
  parameter int ADDR_W    = 17,
  parameter int IDX_W     = 8,
  parameter int RGB_W     = 24,
  parameter int ROM_LAT   = DEF_ROM_LAT,
  parameter int MAP_LAT   = DEF_MAP_LAT,
  parameter bit TRANS_EN  = 1'b0,
  parameter int TRANS_IDX = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [10:0]       x,
  input  logic [9:0]        y,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic              frame_start,
  input  logic              mirror,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_data,
  output logic [IDX_W-1:0]  map_addr,
  input  logic [RGB_W-1:0]  map_data,
  output logic [RGB_W-1:0]  pixel,
  output logic              pixel_valid
);

  localparam int LAT     = sprite_latency(ROM_LAT, MAP_LAT);
  localparam int RNG_DLY = LAT - FRONT_LAT;
  localparam int COL_W   = $clog2(WIDTH + 1);
  localparam int ROW_W   = $clog2(HEIGHT + 1);
  localparam int TX_W    = $clog2(TILES_X + 1);
  localparam int TY_W    = $clog2(TILES_Y + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [TX_W-1:0]  TX_LAST  = TX_W'(TILES_X - 1);
  localparam logic [TY_W-1:0]  TY_LAST  = TY_W'(TILES_Y - 1);

  logic [10:0]       x_q;
  logic [9:0]        y_q;
  logic              mir_q;
  logic              armed_q;
  logic [COL_W-1:0]  col_q, col_d;
  logic [TX_W-1:0]   tile_x_q, tile_x_d;
  logic              col_act_q, col_act_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [TY_W-1:0]   tile_y_q, tile_y_d;
  logic              row_act_q, row_act_d;
  logic [COL_W-1:0]  col_eff_s;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rng_q, rng_d;
  logic              rng_al_s;
  logic              trans_s;
  logic [RGB_W-1:0]  pixel_q, pixel_d;
  logic              pv_q, pv_d;

  // Position/mirror capture; armed_q holds off drawing until the first frame_start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= 11'd0;
      y_q     <= 10'd0;
      mir_q   <= 1'b0;
      armed_q <= 1'b0;
    end else if (frame_start) begin
      x_q     <= x;
      y_q     <= y;
      mir_q   <= mirror;
      armed_q <= 1'b1;
    end else begin
      armed_q <= armed_q;
    end
  end

  // Column walk; a new line (hcount==0) ends a run so wide sprites clip at the right edge.
  always_comb begin
    col_d     = col_q;
    tile_x_d  = tile_x_q;
    col_act_d = col_act_q;
    if (armed_q && (hcount == x_q)) begin
      col_d     = '0;
      tile_x_d  = '0;
      col_act_d = 1'b1;
    end else if (col_act_q && (hcount != 11'd0)) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (tile_x_q == TX_LAST) begin
          col_act_d = 1'b0;
        end else begin
          tile_x_d = tile_x_q + TX_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else begin
      col_act_d = 1'b0;
    end
  end

  // Row walk on line starts; row_base accumulates WIDTH so no multiplier is needed.
  always_comb begin
    row_d      = row_q;
    row_base_d = row_base_q;
    tile_y_d   = tile_y_q;
    row_act_d  = row_act_q;
    if (hcount == 11'd0) begin
      if (armed_q && (vcount == y_q)) begin
        row_d      = '0;
        row_base_d = '0;
        tile_y_d   = '0;
        row_act_d  = 1'b1;
      end else if (row_act_q && (vcount != 10'd0)) begin
        if (row_q == ROW_LAST) begin
          row_d      = '0;
          row_base_d = '0;
          if (tile_y_q == TY_LAST) begin
            row_act_d = 1'b0;
          end else begin
            tile_y_d = tile_y_q + TY_W'(1);
          end
        end else begin
          row_d      = row_q + ROW_W'(1);
          row_base_d = row_base_q + ADDR_W'(WIDTH);
        end
      end else begin
        row_act_d = 1'b0;
      end
    end else begin
      row_act_d = row_act_q;
    end
  end

  // ROM address from counters, with odd tiles optionally read right-to-left.
  always_comb begin
    if (mir_q && tile_x_q[0]) begin
      col_eff_s = COL_LAST - col_q;
    end else begin
      col_eff_s = col_q;
    end
    rng_d = col_act_q && row_act_q;
    if (rng_d) begin
      rom_addr_d = row_base_q + ADDR_W'(col_eff_s);
    end else begin
      rom_addr_d = '0;
    end
  end

  // Counter and address registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q      <= '0;
      tile_x_q   <= '0;
      col_act_q  <= 1'b0;
      row_q      <= '0;
      row_base_q <= '0;
      tile_y_q   <= '0;
      row_act_q  <= 1'b0;
      rom_addr_q <= '0;
      rng_q      <= 1'b0;
    end else begin
      col_q      <= col_d;
      tile_x_q   <= tile_x_d;
      col_act_q  <= col_act_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      tile_y_q   <= tile_y_d;
      row_act_q  <= row_act_d;
      rom_addr_q <= rom_addr_d;
      rng_q      <= rng_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign map_addr = rom_data;

  sprite_delay_line #(.DATA_W(1), .DEPTH(RNG_DLY)) u_rng_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (rng_q),
    .q_o     (rng_al_s)
  );

  if (TRANS_EN) begin : g_trans
    logic [IDX_W-1:0] idx_al_s;
    sprite_delay_line #(.DATA_W(IDX_W), .DEPTH(MAP_LAT)) u_idx_dly (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (rom_data),
      .q_o     (idx_al_s)
    );
    assign trans_s = (idx_al_s == IDX_W'(TRANS_IDX));
  end else begin : g_opaque
    assign trans_s = 1'b0;
  end

  // Output select: colour only for in-range, opaque pixels.
  always_comb begin
    if (rng_al_s && !trans_s) begin
      pixel_d = map_data;
      pv_d    = 1'b1;
    end else begin
      pixel_d = '0;
      pv_d    = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_q <= '0;
      pv_q    <= 1'b0;
    end else begin
      pixel_q <= pixel_d;
      pv_q    <= pv_d;
    end
  end

  assign pixel       = pixel_q;
  assign pixel_valid = pv_q;

endmodule
